// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and buffers {pc, inst}
// pairs in a small circular FIFO toward decode. Define IFETCH_CNT_EN to add fetch_cnt_o.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
`ifdef IFETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc;
    logic [31:0]      buf_pc   [FIFO_DEPTH];
    logic [31:0]      buf_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        issue;
    logic        pop;
    logic        unused_addr_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake: the head transfers to decode on any edge where id_valid_o && id_ready_i.
    // id_valid_o never depends on id_ready_i, and the head fields hold while valid && !ready.
    // A redirect in the same cycle wins: the FIFO is emptied and the pop is irrelevant.
    always_comb begin
        redirect    = flush | branch_flag_i;
        redirect_pc = flush ? {new_pc[31:2], 2'b00} : {branch_target_i[31:2], 2'b00};
        // Fullness uses only the registered count, so a same-cycle pop never frees a slot.
        issue       = rom_ce_o && (count < CNT_FULL) && !redirect;
        pop         = id_valid_o && id_ready_i && !redirect;
    end

    assign unused_addr_bits = ^{new_pc[1:0], branch_target_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            rom_ce_o <= 1'b0;
        end else begin
            rom_ce_o <= 1'b1;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (issue) begin
            buf_pc[wr_ptr]   <= pc;
            buf_inst[wr_ptr] <= rom_inst_i;
        end
    end

    assign rom_addr_o = {pc[31:2], 2'b00};
    assign id_valid_o = (count != '0);
    assign id_pc_o    = id_valid_o ? buf_pc[rd_ptr]   : 32'h0;
    assign id_inst_o  = id_valid_o ? buf_inst[rd_ptr] : 32'h0;

`ifdef IFETCH_CNT_EN
    // Counts pushes; only reset clears it, redirects do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o <= 32'h0;
        end else if (issue) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`endif

endmodule
